load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in RDATA before the load is aborted.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req  input  1  core memory-op request; level, held by core while stall=1.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-007 busAddr  input  32  byte address from ALU result.
REQ-008 busWData  input  32  store data (rs2).
REQ-009 busRData  output  32  aligned, extended load data to the register-file write mux.
REQ-010 stall  output  1  holds PC and register-file write while the op is outstanding.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle pulse: misalignment trap or load timeout.
REQ-013 m_valid / m_ready  output / input  1 / 1  memory request handshake.
REQ-014 m_addr  output  32  word-aligned address ({busAddr[31:2],2'b00}).
REQ-015 m_we  output  1  store strobe qualifier.
REQ-016 m_be  output  4  byte enables.
REQ-017 m_wdata  output  32  lane-replicated store data.
REQ-018 m_rvalid / m_rdata  input / input  1 / 32  load response.

Function
REQ-019 FSM states IDLE, ADDR, RDATA, DONE; encoding free.
REQ-020 IDLE: req=1 -> latch we, funct3, busAddr, busWData; go ADDR; req=0 -> stay.
REQ-021 ADDR: m_valid=1, address/control stable until m_ready=1; handshake -> RDATA (load) or DONE (store).
REQ-022 RDATA: m_rvalid=1 -> capture extended data, go DONE; counter reaching TIMEOUT_CYCLES -> busRData=0, err=1 in DONE, go DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; req is not sampled in DONE.
REQ-024 stall = req & (state!=DONE); stall=0 when req=0.
REQ-025 Minimum latency with m_ready=1 in the first ADDR cycle and m_rvalid on the next cycle: store done 2 cycles after req accepted, load done 3 cycles after req accepted.
REQ-026 m_be: B/BU = 0001<<addr[1:0]; H/HU = 0011<<{addr[1],1'b0}; W = 1111.
REQ-027 m_wdata: B = byte replicated x4; H = half replicated x2; W = unchanged.
REQ-028 Load extract: m_rdata>>(8*addr[1:0]); B/H sign-extend bit 7/15, BU/HU zero-extend, W unchanged.
REQ-029 busRData is registered; it holds the last load value until the next load completes; stores do not change it.
REQ-030 req deasserted mid-op: the op still completes (no abort).
REQ-031 m_rvalid outside RDATA, and m_ready outside ADDR, are ignored.

Reset
REQ-032 On reset: state=IDLE, counter=0, busRData=0, and m_valid, m_we, done, err, stall=0; m_be=0.
REQ-033 Reset mid-op drops the transaction with no done pulse; responses arriving afterwards are ignored.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> IDLE goes directly to DONE with err=1, no m_valid, and no change to busRData.
REQ-035 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned ops are issued with addr low bits forced to the natural alignment (H: addr[0]=0; W: addr[1:0]=0), and err is driven only by timeout.

Verification
REQ-036 SB busAddr=0x102, busWData=0x000000AB, m_ready=1 -> m_be=0100, m_wdata=0xABABABAB, m_addr=0x100, done 2 cycles after req.
REQ-037 LB addr=0x103, m_rdata=0x80FFFFFF -> busRData=0xFFFFFF80; LBU -> 0x00000080.
REQ-038 LH addr=0x202, m_rdata=0x7FFE1234, m_ready delayed 3 cycles -> stall=1 throughout, busRData=0x00007FFE, done at cycle 6.
REQ-039 LW with m_rvalid never asserted -> done and err pulse together after 16 RDATA cycles, busRData=0.
REQ-040 LW addr=0x101 with LSU_MISALIGN_TRAP_EN -> err=1 and done=1 in the cycle after req, m_valid never 1; without the macro -> m_addr=0x100, normal load.
REQ-041 Reset asserted in RDATA, then m_rvalid=1 -> no done pulse, state IDLE, busRData=0.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit bridging core memory ops to a valid/ready memory port
// Optional: LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ADDR, RDATA, DONE} state_t;

    state_t        state;
    logic          op_we;
    logic [2:0]    op_funct3;
    logic [1:0]    op_off;
    logic [CW-1:0] counter;

    logic          req_byte;
    logic          req_half;
    logic          trap;
    logic [1:0]    eff_off;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    // Decode of the incoming request; effective offset is the naturally aligned lane.
    always_comb begin
        req_byte  = (funct3 == 3'b000) || (funct3 == 3'b100);
        req_half  = (funct3 == 3'b001) || (funct3 == 3'b101);
        eff_off   = 2'b00;
        req_be    = 4'b1111;
        req_wdata = busWData;
        if (req_byte) begin
            eff_off   = busAddr[1:0];
            req_be    = 4'b0001 << eff_off;
            req_wdata = {4{busWData[7:0]}};
        end else if (req_half) begin
            eff_off   = {busAddr[1], 1'b0};
            req_be    = 4'b0011 << eff_off;
            req_wdata = {2{busWData[15:0]}};
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = req_half ? busAddr[0] : (!req_byte && (busAddr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        shifted = m_rdata >> {op_off, 3'b000};
        case (op_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = m_rdata;
        endcase
    end

    assign stall = req && (state != DONE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_funct3 <= 3'b000;
            op_off    <= 2'b00;
            counter   <= '0;
            busRData  <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            m_valid   <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= 32'h0;
            m_be      <= 4'b0000;
            m_wdata   <= 32'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_we     <= we;
                        op_funct3 <= funct3;
                        op_off    <= eff_off;
                        if (trap) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= ADDR;
                            m_valid <= 1'b1;
                            m_we    <= we;
                            m_addr  <= {busAddr[31:2], 2'b00};
                            m_be    <= req_be;
                            m_wdata <= req_wdata;
                        end
                    end
                end
                ADDR: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_we    <= 1'b0;
                        counter <= '0;
                        if (op_we) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (m_rvalid) begin
                        busRData <= load_data;
                        state    <= DONE;
                        done     <= 1'b1;
                    end else if (counter == LAST_CNT) begin
                        // Abandoned load returns zero so the core never sees stale data.
                        busRData <= 32'h0;
                        state    <= DONE;
                        done     <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    counter <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
